glyph_row_arbiter: RTL and testbench
====================================

// Module: glyph_row_arbiter
// PURPOSE
//  Shares one single-port, combinational 16x16 glyph row ROM among N_REQ requesters
//  (first operand, second operand, upper display, lower display). Round-robin grant,
//  registered ROM address, registered read data tagged with requester id. Supports
//  single-row fetch and 16-row burst (whole glyph, rows 0..15) for display refresh.
// PARAMETERS
//  N_REQ   4   number of requesters; ID_W = $clog2(N_REQ)
//  ADDR_W  4   glyph row address width (rows 0..2**ADDR_W-1)
//  ROW_W   16  glyph row width in pixels
// PORTS
//  clk        in   1               system clock, all flops rising edge
//  rst_n      in   1               asynchronous active-low reset
//  req        in   N_REQ           per-requester fetch request, level, held until gnt
//  req_burst  in   N_REQ           1 = burst of all rows, 0 = single row req_row
//  req_row    in   N_REQ*ADDR_W    packed row addr, requester i at [i*ADDR_W +: ADDR_W]
//  rom_addr   out  ADDR_W          registered address to glyph ROM
//  rom_data   in   ROW_W           ROM row, combinational from rom_addr
//  gnt        out  N_REQ           one-hot, one-cycle grant pulse
//  rd_valid   out  1               rd_data/rd_id/rd_last valid this cycle
//  rd_data    out  ROW_W           captured ROM row
//  rd_id      out  ID_W            requester owning rd_data
//  rd_last    out  1               final row of a burst (or the single row)
//  busy       out  1               FSM in BURST
// BEHAVIOUR
//  Reset (async, rst_n=0): gnt=0, rom_addr=0, rd_valid=0, rd_data=0, rd_id=0, rd_last=0,
//   busy=0, state=IDLE, row_cnt=0, rr_ptr=N_REQ-1 (requester 0 wins first). Any
//   in-flight burst abandoned; no rd_last produced for it.
//  Arbitration (IDLE only): eligible = req & ~gnt (requester in its gnt cycle is masked,
//   so it may drop req at the end of that cycle without double grant). Winner w = first
//   eligible index scanning rr_ptr+1, rr_ptr+2, ... mod N_REQ. No eligible -> idle cycle.
//  Issue at edge ending arbitration cycle T: gnt<=onehot(w), rr_ptr<=w, issue_id<=w.
//   single: rom_addr<=req_row[w], issue_vld<=1, issue_last<=1, stay IDLE.
//   burst : rom_addr<=0, row_cnt<=0, issue_vld<=1, issue_last<=0, state<=BURST.
//  BURST cycle with row_cnt=k: no arbitration, gnt=0. k<2**ADDR_W-1: rom_addr<=k+1,
//   row_cnt<=k+1, issue_last<=(k+1==2**ADDR_W-1). k==2**ADDR_W-1: state<=IDLE, issue_vld<=0.
//   busy=1 throughout BURST.
//  Capture: each cycle with issue_vld=1, at its ending edge rd_data<=rom_data,
//   rd_id<=issue_id, rd_last<=issue_last, rd_valid<=1; else rd_valid<=0 (rd_data holds).
//  Latency: req sampled in T -> gnt and rom_addr in T+1 -> rd_valid in T+2.
//  Throughput: singles back-to-back, one grant per cycle. Burst: 16 consecutive
//   rd_valid cycles; first grant after burst is 1 cycle after final row address (1 gap).
//  Withdrawal: req dropped before gnt -> request discarded, nothing issued.
//  req_row/req_burst sampled only in the arbitration cycle; later changes ignored.
//  Simultaneous: new req during BURST waits; reset beats every event.
// TESTING  (bench ROM model: rom_data = {4{rom_addr}}, e.g. row 5 -> 16'h5555)
//  1 rst_n=0 mid-activity -> all outputs 0 immediately, not waiting for clk edge.
//  2 req=4'b0100, req_row[2]=5 single -> gnt=4'b0100 @T+1, rom_addr=5, @T+2 rd_valid=1,
//    rd_data=16'h5555, rd_id=2, rd_last=1.
//  3 req=4'b1111 singles, each holding req continuously -> gnt order 0,1,2,3,0,...
//    one per cycle, never the same requester two cycles running.
//  4 req[1] burst -> 16 consecutive rd_valid, rd_data 16'h0000..16'hFFFF, rd_id=1,
//    rd_last only on row 15; req[0] raised at burst row 3 -> gnt[0] only after burst ends.
//  5 rst_n pulse low at burst row 7 -> rd_valid=0, busy=0; after release no rd_valid
//    until a new req; first grant goes to requester 0.
//  6 req[3] raised then dropped during BURST -> gnt[3] never asserted, no rd_id=3 data.

Source files
------------

// File: rtl/glyph_row_arbiter.sv
// Round-robin arbiter sharing one combinational glyph row ROM among N_REQ requesters.
// Serves single-row fetches or whole-glyph bursts; read data returns tagged with the owner id.
module glyph_row_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 4,
    parameter int ROW_W  = 16,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_burst,
    input  logic [N_REQ*ADDR_W-1:0] req_row,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [ROW_W-1:0]        rom_data,
    output logic [N_REQ-1:0]        gnt,
    output logic                    rd_valid,
    output logic [ROW_W-1:0]        rd_data,
    output logic [ID_W-1:0]         rd_id,
    output logic                    rd_last,
    output logic                    busy
);

    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [ADDR_W-1:0] LAST_ROW = '1;

    state_t                         state, state_d;
    logic [N_REQ-1:0][ADDR_W-1:0]   rows;
    logic [N_REQ-1:0]               eligible;
    logic                           found;
    logic [ID_W-1:0]                win;

    logic [ID_W-1:0]                rr_ptr, rr_d;
    logic [ID_W-1:0]                issue_id, id_d;
    logic                           issue_vld, ivld_d;
    logic                           issue_last, ilast_d;
    logic [ADDR_W-1:0]              row_cnt, cnt_d, cnt_inc;
    logic [ADDR_W-1:0]              addr_d;
    logic [N_REQ-1:0]               gnt_d;

    assign rows     = req_row;
    // A requester in its grant cycle is masked so it can release req without a second grant.
    assign eligible = req & ~gnt;
    assign cnt_inc  = row_cnt + 1'b1;
    assign busy     = (state == BURST);

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!found && eligible[(int'(rr_ptr) + i) % N_REQ]) begin
                found = 1'b1;
                win   = ID_W'((int'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d = state;
        gnt_d   = '0;
        rr_d    = rr_ptr;
        id_d    = issue_id;
        addr_d  = rom_addr;
        cnt_d   = row_cnt;
        ivld_d  = 1'b0;
        ilast_d = issue_last;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_d  = N_REQ'(1) << win;
                    rr_d   = win;
                    id_d   = win;
                    ivld_d = 1'b1;
                    if (req_burst[win]) begin
                        addr_d  = '0;
                        cnt_d   = '0;
                        ilast_d = 1'b0;
                        state_d = BURST;
                    end else begin
                        addr_d  = rows[win];
                        ilast_d = 1'b1;
                    end
                end
            end
            BURST: begin
                if (row_cnt != LAST_ROW) begin
                    ivld_d  = 1'b1;
                    addr_d  = cnt_inc;
                    cnt_d   = cnt_inc;
                    ilast_d = (cnt_inc == LAST_ROW);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= '0;
            rr_ptr     <= ID_W'(N_REQ - 1);
            issue_id   <= '0;
            issue_vld  <= 1'b0;
            issue_last <= 1'b0;
            rom_addr   <= '0;
            row_cnt    <= '0;
        end else begin
            state      <= state_d;
            gnt        <= gnt_d;
            rr_ptr     <= rr_d;
            issue_id   <= id_d;
            issue_vld  <= ivld_d;
            issue_last <= ilast_d;
            rom_addr   <= addr_d;
            row_cnt    <= cnt_d;
        end
    end

    // ROM row is captured one cycle after its address is issued; rd_data holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_id    <= '0;
            rd_last  <= 1'b0;
        end else begin
            rd_valid <= issue_vld;
            if (issue_vld) begin
                rd_data <= rom_data;
                rd_id   <= issue_id;
                rd_last <= issue_last;
            end
        end
    end

endmodule

// File: tb/tb_glyph_row_arbiter.sv
// Directed bench for glyph_row_arbiter; ROM model returns the row address replicated 4 times.
module tb_glyph_row_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  req_burst = '0;
    logic [15:0] req_row = '0;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic [3:0]  gnt;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [1:0]  rd_id;
    logic        rd_last;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    glyph_row_arbiter #(.N_REQ(4), .ADDR_W(4), .ROW_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_burst(req_burst), .req_row(req_row),
        .rom_addr(rom_addr), .rom_data(rom_data), .gnt(gnt), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_id(rd_id), .rd_last(rd_last), .busy(busy)
    );

    always #5 clk = ~clk;
    assign rom_data = {4{rom_addr}};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rowdat(input int r);
        logic [3:0] a;
        a = 4'(r);
        return {4{a}};
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},      32'(gnt), 32'h0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'h0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
        chk({tag, "_rd_data"},  32'(rd_data), 32'h0);
        chk({tag, "_rd_id"},    32'(rd_id), 32'h0);
        chk({tag, "_rd_last"},  32'(rd_last), 32'h0);
        chk({tag, "_busy"},     32'(busy), 32'h0);
    endtask

    initial begin
        // reset state
        #3;
        chk_zero("rst");
        tick; tick;
        rst_n = 1'b1;

        // single fetch, requester 2, row 5
        req = 4'b0100;
        req_row[11:8] = 4'd5;
        tick;
        chk("s_gnt", 32'(gnt), 32'h4);
        chk("s_addr", 32'(rom_addr), 32'h5);
        chk("s_vld0", 32'(rd_valid), 32'h0);
        req = '0;
        tick;
        chk("s_vld", 32'(rd_valid), 32'h1);
        chk("s_data", 32'(rd_data), 32'h5555);
        chk("s_id", 32'(rd_id), 32'h2);
        chk("s_last", 32'(rd_last), 32'h1);
        chk("s_gnt_off", 32'(gnt), 32'h0);

        // round robin from reset pointer: 0,1,2,3,0,...
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req_row = 16'hBA98;
        req = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            tick;
            chk($sformatf("rr_gnt%0d", j), 32'(gnt), 32'(1 << (j % 4)));
            chk($sformatf("rr_addr%0d", j), 32'(rom_addr), 32'((j % 4) + 8));
            if (j > 0) begin
                chk($sformatf("rr_vld%0d", j), 32'(rd_valid), 32'h1);
                chk($sformatf("rr_id%0d", j), 32'(rd_id), 32'((j - 1) % 4));
                chk($sformatf("rr_data%0d", j), 32'(rd_data), 32'(rowdat(((j - 1) % 4) + 8)));
            end
        end
        req = '0;
        tick;
        chk("rr_tail_gnt", 32'(gnt), 32'h0);
        chk("rr_tail_id", 32'(rd_id), 32'h3);
        chk("rr_tail_vld", 32'(rd_valid), 32'h1);
        tick;
        chk("rr_idle_vld", 32'(rd_valid), 32'h0);

        // burst for requester 1; requester 0 raised at row 3 waits for the burst
        req = 4'b0010;
        req_burst = 4'b0010;
        req_row = 16'h00C0;
        tick;
        chk("b_gnt", 32'(gnt), 32'h2);
        chk("b_busy", 32'(busy), 32'h1);
        chk("b_addr", 32'(rom_addr), 32'h0);
        chk("b_vld0", 32'(rd_valid), 32'h0);
        req = '0;
        req_burst = '0;
        for (int c = 2; c <= 17; c++) begin
            tick;
            chk($sformatf("b_busy%0d", c), 32'(busy), 32'(c <= 16));
            chk($sformatf("b_gnt%0d", c), 32'(gnt), 32'h0);
            if (c <= 16) chk($sformatf("b_addr%0d", c), 32'(rom_addr), 32'(c - 1));
            chk($sformatf("b_vld%0d", c), 32'(rd_valid), 32'h1);
            chk($sformatf("b_data%0d", c), 32'(rd_data), 32'(rowdat(c - 2)));
            chk($sformatf("b_id%0d", c), 32'(rd_id), 32'h1);
            chk($sformatf("b_last%0d", c), 32'(rd_last), 32'(c == 17));
            if (c == 4) begin
                req = 4'b0001;
                req_row[3:0] = 4'd2;
            end
        end
        tick;
        chk("b_after_gnt", 32'(gnt), 32'h1);
        chk("b_after_addr", 32'(rom_addr), 32'h2);
        chk("b_after_busy", 32'(busy), 32'h0);
        chk("b_after_vld", 32'(rd_valid), 32'h0);
        req = '0;
        tick;
        chk("b_after_rvld", 32'(rd_valid), 32'h1);
        chk("b_after_id", 32'(rd_id), 32'h0);
        chk("b_after_data", 32'(rd_data), 32'h2222);
        chk("b_after_last", 32'(rd_last), 32'h1);

        // reset pulse at burst row 7
        req = 4'b0100;
        req_burst = 4'b0100;
        tick;
        chk("r_gnt", 32'(gnt), 32'h4);
        req = '0;
        req_burst = '0;
        for (int c = 2; c <= 8; c++) begin
            tick;
            chk($sformatf("r_addr%0d", c), 32'(rom_addr), 32'(c - 1));
            chk($sformatf("r_vld%0d", c), 32'(rd_valid), 32'h1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        tick; tick;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk($sformatf("post_vld%0d", c), 32'(rd_valid), 32'h0);
            chk($sformatf("post_busy%0d", c), 32'(busy), 32'h0);
            chk($sformatf("post_gnt%0d", c), 32'(gnt), 32'h0);
        end
        req = 4'b1111;
        req_row = 16'hBA98;
        tick;
        chk("post_first_gnt", 32'(gnt), 32'h1);
        chk("post_first_addr", 32'(rom_addr), 32'h8);
        req = '0;
        tick;
        chk("post_first_vld", 32'(rd_valid), 32'h1);
        chk("post_first_id", 32'(rd_id), 32'h0);
        chk("post_first_data", 32'(rd_data), 32'h8888);
        chk("post_first_gnt_off", 32'(gnt), 32'h0);

        // requester 3 raised and withdrawn during a burst never gets served
        req = 4'b0010;
        req_burst = 4'b0010;
        tick;
        chk("w_gnt", 32'(gnt), 32'h2);
        req = '0;
        req_burst = '0;
        for (int c = 2; c <= 19; c++) begin
            tick;
            chk($sformatf("w_gnt%0d", c), 32'(gnt), 32'h0);
            if (c <= 17) begin
                chk($sformatf("w_vld%0d", c), 32'(rd_valid), 32'h1);
                chk($sformatf("w_id%0d", c), 32'(rd_id), 32'h1);
            end else begin
                chk($sformatf("w_vld%0d", c), 32'(rd_valid), 32'h0);
            end
            if (c == 3) req = 4'b1000;
            if (c == 6) req = '0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
